core8_switches_arbiter: RTL and testbench
=========================================

# core8_switches_arbiter

Round-robin read arbiter that shares the single switches PIO input port (18-bit `in_port`, 2-bit address, registered `readdata`) among the eight Nios cores of the Core8 system. Each core sees its own Avalon-MM read-only slave with `waitrequest`. The arbiter serialises accesses onto the one PIO slave, accounts for its one-cycle registered read latency, and returns the data to the granted core only.

## Interface
Parameters:
- `N_REQ`, 8: number of requesting cores.
- `ADDR_W`, 2: PIO address width.
- `DATA_W`, 32: readdata width.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `m_read`  in  N_REQ  per-core read request, bit i = core i.
- `m_address`  in  N_REQ*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W].
- `m_waitrequest`  out  N_REQ  per-core waitrequest; low only in that core's response cycle.
- `m_readdata`  out  DATA_W  registered response data, shared by all cores; valid only for the core whose waitrequest is low.
- `s_address`  out  ADDR_W  address to the switches PIO.
- `s_readdata`  in  DATA_W  PIO registered readdata.
- `grant`  out  N_REQ  one-hot current owner, all zero when idle; debug only.

## Operation
- FSM states: IDLE, ISSUE, CAPT, RESP.
- IDLE
  - If any `m_read` bit is set, pick a winner and register `grant` and `s_address` from that core's address. Go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: `s_address` is held. The PIO samples it at the end of this cycle. Go to CAPT.
- CAPT: `s_readdata` is valid. Register it into `m_readdata`. Go to RESP.
- RESP
  - `m_waitrequest[g]`=0 for the granted core g; all other bits stay 1.
  - Clear `grant`, update the round-robin pointer to g, and go to IDLE.
- Round-robin selection:
  - Search starts at pointer+1 and wraps modulo N_REQ.
  - The pointer resets to N_REQ-1, so core 0 wins first after reset.
- Cores must hold `m_read` and `m_address` stable until waitrequest is low (Avalon rule). The arbiter latches the address at grant and does not re-sample it.
- If a core drops `m_read` mid-transaction, the transaction still completes on the slave and the response cycle is still produced. No error is flagged.
- Non-zero addresses are passed through unchanged. The PIO returns 0 for them, and that 0 is delivered.
- Upper bits of `m_readdata` are exactly as `s_readdata`; there is no masking.

## Timing
- Reset values: state=IDLE, `m_waitrequest`=all 1, `m_readdata`=0, `s_address`=0, `grant`=0, pointer=N_REQ-1.
- Latency with `m_read` first high in cycle 0 and the arbiter idle:
  - cycle 1 ISSUE;
  - cycle 2 CAPT;
  - cycle 3 RESP, with waitrequest low and data valid.
- Throughput: one read per 4 cycles. There is no back-to-back bypass from RESP into ISSUE.
- Simultaneous requests are resolved in the IDLE cycle only. Requests arriving during ISSUE, CAPT or RESP wait for the next IDLE.
- The switch value returned is the one `in_port` held at the end of ISSUE. Switch changes after that edge are not reflected.
- Reset asserted mid-transaction:
  - all outputs return to reset values immediately (asynchronous);
  - the in-flight transaction is dropped with no response;
  - the core re-issues its request after reset.

## Configuration
- Macro: `CORE8_SWARB_FIXED_PRIO_EN`.
- Defined: fixed priority; the lowest-index requesting core always wins and the pointer logic is removed. Core 0 can starve the others.
- Undefined (default): round-robin as described in Operation.

## Structure
- Package `core8_swarb_pkg` holds:
  - the state enum (IDLE, ISSUE, CAPT, RESP);
  - default constants N_REQ=8, ADDR_W=2, DATA_W=32;
  - a function returning the one-hot to index encoding.
- Sub-module `core8_rr_pick` holds the combinational winner selection:
  - inputs: request vector and pointer;
  - output: one-hot winner;
  - the macro switches its body between round-robin and fixed priority.
- FSM, registers and the slave interface stay in the top module.

## Test plan
- Single read: core 3 reads address 0 with `in_port`=18'h2A5A5 → `m_waitrequest[3]` low exactly in cycle 3, `m_readdata`=32'h0002A5A5, all other waitrequest bits stay 1.
- All eight cores request at once and hold → responses in order 0,1,…,7, 4 cycles apart, each carrying the current switch value.
- Round-robin fairness: core 0 re-requests immediately after each response while core 5 also requests → grants alternate 0,5,0,5. With `CORE8_SWARB_FIXED_PRIO_EN` defined → grants are 0,0,0 and core 5 is starved.
- Address 1 from core 2 with `in_port`=18'h3FFFF → `s_address`=1 in ISSUE, `m_readdata`=0.
- Reset in CAPT → all outputs go to reset values in the same cycle. After release, core 0 is granted first and no stale response appears.
- `in_port` changes from 18'h00001 to 18'h00002 one cycle after ISSUE → response is 32'h00000001.

Source files
------------

// File: rtl/core8_swarb_pkg.sv
// Shared types, default sizes and helpers for the Core8 switches read arbiter.
// Optional feature macro: CORE8_SWARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
package core8_swarb_pkg;

    localparam int DEF_N_REQ  = 8;
    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_IDX_W  = $clog2(DEF_N_REQ);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPT,
        RESP
    } swarb_state_t;

    // OR-reduction encoder: a one-hot input yields its bit position, all-zero yields 0
    function automatic logic [DEF_IDX_W-1:0] onehot_to_idx(input logic [DEF_N_REQ-1:0] onehot);
        logic [DEF_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < DEF_N_REQ; i++) begin
            if (onehot[i]) begin
                idx = idx | DEF_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/core8_switches_arbiter_if.sv
// Bus bundle between the eight cores, the arbiter and the switches PIO.
// The slave modport is the arbiter's view; the master modport is the
// surrounding system (cores driving requests, PIO returning readdata).
// Optional feature macro: CORE8_SWARB_FIXED_PRIO_EN (no effect on this file).
interface core8_switches_arbiter_if
    import core8_swarb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [N_REQ-1:0]        m_read;
    logic [N_REQ*ADDR_W-1:0] m_address;
    logic [N_REQ-1:0]        m_waitrequest;
    logic [DATA_W-1:0]       m_readdata;
    logic [ADDR_W-1:0]       s_address;
    logic [DATA_W-1:0]       s_readdata;
    logic [N_REQ-1:0]        grant;

    modport slave (
        input  m_read,
        input  m_address,
        input  s_readdata,
        output m_waitrequest,
        output m_readdata,
        output s_address,
        output grant
    );

    modport master (
        output m_read,
        output m_address,
        output s_readdata,
        input  m_waitrequest,
        input  m_readdata,
        input  s_address,
        input  grant
    );

endinterface

// File: rtl/core8_rr_pick.sv
// Combinational winner selection for the switches arbiter.
// Default: round-robin search starting one past the pointer, wrapping.
// With CORE8_SWARB_FIXED_PRIO_EN defined: lowest-index requester always wins.
module core8_rr_pick
    import core8_swarb_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] winner
);

`ifdef CORE8_SWARB_FIXED_PRIO_EN
    // The pointer has no meaning under fixed priority
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Scan from the top down so the lowest requesting index is written last
    always_comb begin
        winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner    = '0;
                winner[i] = 1'b1;
            end
        end
    end
`else
    logic found;
    int   cand;

    // Walk ptr+1, ptr+2, ... modulo N_REQ and take the first requester seen
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!found && req[cand]) begin
                winner[cand] = 1'b1;
                found        = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/core8_switches_arbiter.sv
// Read arbiter sharing the single switches PIO among the eight Core8 cores.
// One read per four cycles: IDLE (arbitrate) -> ISSUE (PIO samples address)
// -> CAPT (capture registered PIO data) -> RESP (granted core's waitrequest low).
// Optional feature macro: CORE8_SWARB_FIXED_PRIO_EN selects fixed priority
// and removes the round-robin pointer.
module core8_switches_arbiter
    import core8_swarb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input logic clk,
    input logic reset_n,
    core8_switches_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(N_REQ);

    swarb_state_t      state;
    swarb_state_t      state_nxt;
    logic [N_REQ-1:0]  grant_q;
    logic [N_REQ-1:0]  grant_nxt;
    logic [ADDR_W-1:0] s_address_q;
    logic [ADDR_W-1:0] s_address_nxt;
    logic [DATA_W-1:0] readdata_q;
    logic [DATA_W-1:0] readdata_nxt;
    logic [N_REQ-1:0]  winner;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  ptr_q;

`ifdef CORE8_SWARB_FIXED_PRIO_EN
    assign ptr_q = '0;
`else
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] grant_idx;
    assign grant_idx = onehot_to_idx(grant_q);
`endif

    core8_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (bus.m_read),
        .ptr    (ptr_q),
        .winner (winner)
    );

    assign win_idx = onehot_to_idx(winner);

    // Next-state logic: arbitration only in IDLE, data capture in CAPT, release in RESP
    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant_q;
        s_address_nxt = s_address_q;
        readdata_nxt  = readdata_q;
`ifndef CORE8_SWARB_FIXED_PRIO_EN
        ptr_nxt       = ptr_q;
`endif
        case (state)
            IDLE: begin
                if (|bus.m_read) begin
                    grant_nxt     = winner;
                    s_address_nxt = bus.m_address[int'(win_idx)*ADDR_W +: ADDR_W];
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = CAPT;
            end
            CAPT: begin
                readdata_nxt = bus.s_readdata;
                state_nxt    = RESP;
            end
            RESP: begin
                grant_nxt = '0;
`ifndef CORE8_SWARB_FIXED_PRIO_EN
                ptr_nxt   = grant_idx;
`endif
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset drops any in-flight read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant_q     <= '0;
            s_address_q <= '0;
            readdata_q  <= '0;
`ifndef CORE8_SWARB_FIXED_PRIO_EN
            ptr_q       <= IDX_W'(N_REQ - 1);
`endif
        end else begin
            state       <= state_nxt;
            grant_q     <= grant_nxt;
            s_address_q <= s_address_nxt;
            readdata_q  <= readdata_nxt;
`ifndef CORE8_SWARB_FIXED_PRIO_EN
            ptr_q       <= ptr_nxt;
`endif
        end
    end

    // Grant is still held during RESP, so it directly selects which waitrequest drops
    assign bus.m_waitrequest = (state == RESP) ? ~grant_q : '1;
    assign bus.m_readdata    = readdata_q;
    assign bus.s_address     = s_address_q;
    assign bus.grant         = grant_q;

endmodule

// File: tb/tb_core8_switches_arbiter.sv
// Scoreboard bench for core8_switches_arbiter.
// A transaction-level model predicts winner, response cycle and data;
// a negedge monitor pops and compares whenever a waitrequest drops.
// Optional feature macro: CORE8_SWARB_FIXED_PRIO_EN (model follows it).
module tb_core8_switches_arbiter;
    import core8_swarb_pkg::*;

    localparam int N  = DEF_N_REQ;
    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;

    typedef struct {
        int          core;
        logic [31:0] data;
        int          cyc;
    } resp_t;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [17:0] in_port = '0;
    int          errors  = 0;
    int          checks  = 0;
    int          cyc     = 0;

    resp_t       sb_q[$];
    resp_t       new_r;
    resp_t       mon_r;

    bit          active    = 1'b0;
    int          t0        = 0;
    int          cur_w     = 0;
    int          ptr       = N - 1;
    logic [1:0]  cur_addr  = '0;
    logic [N-1:0] exp_grant = '0;
    logic [N-1:0] exp_wr;
    int          low_idx;

    bit          rand_en = 1'b0;
    logic [N-1:0] sticky = '0;

    core8_switches_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    core8_switches_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Cycle number: within cycle k, cyc == k
    always @(posedge clk) cyc <= cyc + 1;

    // Switches PIO: registered readdata, only address 0 returns the switches
    always @(posedge clk) bus.s_readdata <= (bus.s_address == '0) ? {14'b0, in_port} : '0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int ref_pick(input logic [N-1:0] req, input int p);
`ifdef CORE8_SWARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (req[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (req[(p + k) % N]) return (p + k) % N;
`endif
        return -1;
    endfunction

    // Reference model: one transaction per 4 cycles, response 3 cycles after arbitration,
    // data is the switch value at the end of the cycle after arbitration
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active    = 1'b0;
            ptr       = N - 1;
            exp_grant = '0;
            sb_q.delete();
        end else if (!active) begin
            if (bus.m_read != '0) begin
                cur_w     = ref_pick(bus.m_read, ptr);
                cur_addr  = bus.m_address[cur_w*AW +: AW];
                t0        = cyc;
                active    = 1'b1;
                exp_grant = '0;
                exp_grant[cur_w] = 1'b1;
            end
        end else begin
            if (cyc == t0 + 1) begin
                new_r.core = cur_w;
                new_r.data = (cur_addr == 2'd0) ? {14'b0, in_port} : 32'h0;
                new_r.cyc  = t0 + 3;
                sb_q.push_back(new_r);
            end
            if (cyc == t0 + 3) begin
                active    = 1'b0;
                exp_grant = '0;
                ptr       = cur_w;
            end
        end
    end

    // Monitor: per-cycle waitrequest/grant/address checks and scoreboard pop on responses
    always @(negedge clk) begin
        exp_wr = '1;
        if (active && cyc == t0 + 3) exp_wr[cur_w] = 1'b0;
        check_output("waitrequest", 32'(bus.m_waitrequest), 32'(exp_wr));
        check_output("grant", 32'(bus.grant), 32'(exp_grant));
        if (active && cyc == t0 + 1) check_output("s_address_issue", 32'(bus.s_address), 32'(cur_addr));
        if (bus.m_waitrequest != '1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_response: waitrequest %h with no expected response (cycle %0d)",
                         bus.m_waitrequest, cyc);
            end else begin
                mon_r   = sb_q.pop_front();
                low_idx = -1;
                for (int i = N - 1; i >= 0; i--) if (!bus.m_waitrequest[i]) low_idx = i;
                check_output("resp_core", 32'(low_idx), 32'(mon_r.core));
                check_output("resp_data", bus.m_readdata, mon_r.data);
                check_output("resp_cycle", 32'(cyc), 32'(mon_r.cyc));
            end
        end
    end

    // Core agents: drop on completion, re-request when sticky, random traffic when enabled
    task automatic agent_step();
        for (int i = 0; i < N; i++) begin
            if (bus.m_read[i] && !bus.m_waitrequest[i]) begin
                bus.m_read[i] = 1'b0;
            end else if (!bus.m_read[i] && (sticky[i] || (rand_en && $urandom_range(3) == 0))) begin
                bus.m_read[i] = 1'b1;
                bus.m_address[i*AW +: AW] = (rand_en && $urandom_range(2) == 0) ? AW'($urandom_range(3)) : '0;
            end else if (rand_en && bus.m_read[i] && $urandom_range(31) == 0) begin
                bus.m_read[i] = 1'b0;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            agent_step();
        end
    endtask

    task automatic apply_stimulus(input int core, input logic [1:0] addr);
        bus.m_read[core] = 1'b1;
        bus.m_address[core*AW +: AW] = addr;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((bus.m_read != '0 || active || sb_q.size() != 0) && n < limit) begin
            tick(1);
            n++;
        end
        if (bus.m_read != '0 || active || sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: still busy after %0d cycles, %0d responses outstanding", limit, sb_q.size());
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_waitrequest"}, 32'(bus.m_waitrequest), 32'hFF);
        check_output({tag, "_readdata"}, bus.m_readdata, 32'h0);
        check_output({tag, "_s_address"}, 32'(bus.s_address), 32'h0);
        check_output({tag, "_grant"}, 32'(bus.grant), 32'h0);
    endtask

    initial begin
        bus.m_read    = '0;
        bus.m_address = '0;
        reset_n       = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset_n = 1'b1;

        $display("[TB] all eight cores request at once");
        for (int i = 0; i < N; i++) apply_stimulus(i, 2'd0);
        repeat (36) begin
            tick(1);
            in_port = 18'($urandom);
        end
        wait_idle(60);

        $display("[TB] single read from core 3");
        in_port = 18'h2A5A5;
        apply_stimulus(3, 2'd0);
        wait_idle(20);

        $display("[TB] fairness between cores 0 and 5");
        sticky = 8'b0010_0001;
        apply_stimulus(0, 2'd0);
        apply_stimulus(5, 2'd0);
        tick(24);
        sticky = '0;
        wait_idle(30);

        $display("[TB] address 1 from core 2");
        in_port = 18'h3FFFF;
        apply_stimulus(2, 2'd1);
        wait_idle(20);

        $display("[TB] switch change after ISSUE is not reflected");
        in_port = 18'h00001;
        apply_stimulus(6, 2'd0);
        tick(2);
        in_port = 18'h00002;
        wait_idle(20);

        $display("[TB] reset during CAPT");
        in_port = 18'h01234;
        apply_stimulus(4, 2'd0);
        tick(1);
        @(posedge clk);
        #2;
        reset_n    = 1'b0;
        bus.m_read = '0;
        #1;
        check_reset_values("capt_rst");
        tick(2);
        reset_n = 1'b1;
        apply_stimulus(4, 2'd0);
        apply_stimulus(0, 2'd0);
        wait_idle(30);

        $display("[TB] randomized traffic");
        rand_en = 1'b1;
        repeat (400) begin
            tick(1);
            if ($urandom_range(1) == 1) in_port = 18'($urandom);
        end
        rand_en = 1'b0;
        wait_idle(200);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
